video_timing_checker: RTL and testbench

- Downstream monitor on the HDMI_main video output: h_sync, v_sync, data_enable, rgb_channel.
- Measures 640x480@60 raster timing against parameters, flags deviations with sticky error bits, and reports lock status.
- Produces a per-frame pixel checksum so benches and on-board debug can confirm pattern and switch changes without dumping frames.
- Runs in the pixel clock domain.

---
 rtl/video_timing_pkg.sv | 40 ++++
 rtl/sync_edge_detect.sv | 29 ++
 rtl/video_timing_checker.sv | 183 ++++++++++++++++++
 tb/tb_video_timing_checker.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared 640x480@60 raster constants, FSM encodings and error-bit indices
// for the HDMI_main output timing checker.
package video_timing_pkg;

  localparam int unsigned H_ACTIVE    = 640;
  localparam int unsigned H_FRONT     = 16;
  localparam int unsigned H_SYNC_W    = 96;
  localparam int unsigned H_BACK      = 48;
  localparam int unsigned H_TOTAL     = 800;
  localparam int unsigned V_ACTIVE    = 480;
  localparam int unsigned V_FRONT     = 10;
  localparam int unsigned V_SYNC_W    = 2;
  localparam int unsigned V_BACK      = 33;
  localparam int unsigned V_TOTAL     = 525;
  localparam bit          SYNC_POL    = 1'b0;
  localparam int unsigned LOCK_FRAMES = 2;

  localparam int unsigned CNT_W  = 11;
  localparam int unsigned RGB_W  = 24;
  localparam int unsigned FCNT_W = 16;
  localparam int unsigned GOOD_W = 8;
  localparam int unsigned ERR_W  = 6;

  localparam int unsigned ERR_H_TOTAL  = 0;
  localparam int unsigned ERR_H_SYNC   = 1;
  localparam int unsigned ERR_H_ACTIVE = 2;
  localparam int unsigned ERR_V_TOTAL  = 3;
  localparam int unsigned ERR_V_ACTIVE = 4;
  localparam int unsigned ERR_TIMEOUT  = 5;

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_ALIGN  = 2'd1;
  localparam logic [1:0] ST_CHECK  = 2'd2;

  // Saturating increment used by all measurement counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Registers one raster control input, normalises it so 1 means asserted,
// and produces single-cycle leading/trailing edge pulses.
module sync_edge_detect #(
  parameter bit ACT_LVL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  logic level_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      level   <= 1'b0;
      level_d <= 1'b0;
    end else begin
      level   <= (raw == ACT_LVL);
      level_d <= level;
    end
  end

  assign rise_c = level & ~level_d;
  assign fall_c = ~level & level_d;

endmodule

// File: rtl/video_timing_checker.sv
// Pixel-clock monitor of the HDMI_main raster: measures line/frame timing,
// keeps sticky error flags, tracks lock and sums pixel data per frame.
module video_timing_checker #(
  parameter int unsigned H_ACTIVE    = video_timing_pkg::H_ACTIVE,
  parameter int unsigned H_TOTAL     = video_timing_pkg::H_TOTAL,
  parameter int unsigned H_SYNC_W    = video_timing_pkg::H_SYNC_W,
  parameter int unsigned V_ACTIVE    = video_timing_pkg::V_ACTIVE,
  parameter int unsigned V_TOTAL     = video_timing_pkg::V_TOTAL,
  parameter int unsigned LOCK_FRAMES = video_timing_pkg::LOCK_FRAMES,
  parameter bit          SYNC_POL    = video_timing_pkg::SYNC_POL
) (
  input  logic                                clock_25,
  input  logic                                reset,
  input  logic                                h_sync,
  input  logic                                v_sync,
  input  logic                                data_enable,
  input  logic [video_timing_pkg::RGB_W-1:0]  rgb_channel,
  input  logic                                clear_errors,
  output logic                                locked,
  output logic                                frame_done,
  output logic [video_timing_pkg::FCNT_W-1:0] frame_count,
  output logic [video_timing_pkg::RGB_W-1:0]  frame_checksum,
  output logic                                err_h_total,
  output logic                                err_h_sync,
  output logic                                err_h_active,
  output logic                                err_v_total,
  output logic                                err_v_active,
  output logic                                err_timeout
);

  import video_timing_pkg::*;

  localparam logic [CNT_W-1:0]  H_TOTAL_M1 = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0]  H_SYNC_M1  = CNT_W'(H_SYNC_W - 1);
  localparam logic [CNT_W-1:0]  H_ACT_CNT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0]  V_TOT_CNT  = CNT_W'(V_TOTAL);
  localparam logic [CNT_W-1:0]  V_ACT_CNT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0]  TO_LIMIT   = CNT_W'(2 * H_TOTAL - 1);
  localparam logic [GOOD_W-1:0] LOCK_M1    = GOOD_W'(LOCK_FRAMES - 1);

  logic hs_lvl, hs_rise_c, hs_fall_c;
  logic vs_lvl, vs_rise_c, vs_fall_c;
  logic de_lvl, de_rise_c, de_fall_c;

  logic [1:0]        state, state_nxt;
  logic [CNT_W-1:0]  h_cnt, de_run, line_cnt, active_lines;
  logic              run_open, frame_err;
  logic [RGB_W-1:0]  rgb_q, sum_acc;
  logic [GOOD_W-1:0] good_frames;
  logic [ERR_W-1:0]  err_q, det_c;
  logic              tracking_c, in_check_c, timeout_c, open_c, close_c;
  logic              run_end_c, frame_bad_c;
  logic              unused_edges;

  sync_edge_detect #(.ACT_LVL(SYNC_POL)) u_hs (
    .clk(clock_25), .reset(reset), .raw(h_sync),
    .level(hs_lvl), .rise_c(hs_rise_c), .fall_c(hs_fall_c)
  );

  sync_edge_detect #(.ACT_LVL(SYNC_POL)) u_vs (
    .clk(clock_25), .reset(reset), .raw(v_sync),
    .level(vs_lvl), .rise_c(vs_rise_c), .fall_c(vs_fall_c)
  );

  sync_edge_detect #(.ACT_LVL(1'b1)) u_de (
    .clk(clock_25), .reset(reset), .raw(data_enable),
    .level(de_lvl), .rise_c(de_rise_c), .fall_c(de_fall_c)
  );

  assign unused_edges = ^{hs_lvl, vs_lvl, vs_fall_c};

  // State register.
  always_ff @(posedge clock_25) begin
    if (reset) state <= ST_SEARCH;
    else       state <= state_nxt;
  end

  // Next state and per-cycle error detection.
  always_comb begin
    state_nxt   = state;
    det_c       = '0;
    tracking_c  = (state == ST_ALIGN) || (state == ST_CHECK);
    in_check_c  = (state == ST_CHECK);
    timeout_c   = tracking_c && !hs_rise_c && (h_cnt == TO_LIMIT);
    run_end_c   = run_open && (de_fall_c || (hs_rise_c && de_lvl));
    open_c      = (state == ST_ALIGN) && vs_rise_c && !timeout_c;
    close_c     = in_check_c && vs_rise_c && !timeout_c;

    det_c[ERR_H_TOTAL]  = in_check_c && hs_rise_c && (h_cnt != H_TOTAL_M1);
    det_c[ERR_H_SYNC]   = in_check_c && hs_fall_c && (h_cnt != H_SYNC_M1);
    det_c[ERR_H_ACTIVE] = in_check_c && run_end_c &&
                          ((hs_rise_c && de_lvl) || (de_run != H_ACT_CNT));
    det_c[ERR_V_TOTAL]  = close_c && (line_cnt != V_TOT_CNT);
    det_c[ERR_V_ACTIVE] = close_c && (active_lines != V_ACT_CNT);
    det_c[ERR_TIMEOUT]  = timeout_c;
    frame_bad_c         = frame_err || (|det_c);

    case (state)
      ST_SEARCH: if (hs_rise_c) state_nxt = ST_ALIGN;
      ST_ALIGN: begin
        if (timeout_c)      state_nxt = ST_SEARCH;
        else if (vs_rise_c) state_nxt = ST_CHECK;
      end
      ST_CHECK:  if (timeout_c) state_nxt = ST_SEARCH;
      default:   state_nxt = ST_SEARCH;
    endcase
  end

  // Measurement counters, frame bookkeeping and registered outputs.
  always_ff @(posedge clock_25) begin
    if (reset) begin
      h_cnt          <= '0;
      de_run         <= '0;
      line_cnt       <= '0;
      active_lines   <= '0;
      run_open       <= 1'b0;
      frame_err      <= 1'b0;
      rgb_q          <= '0;
      sum_acc        <= '0;
      good_frames    <= '0;
      err_q          <= '0;
      locked         <= 1'b0;
      frame_done     <= 1'b0;
      frame_count    <= '0;
      frame_checksum <= '0;
    end else begin
      frame_done <= 1'b0;
      err_q      <= (clear_errors ? '0 : err_q) | det_c;
      rgb_q      <= rgb_channel;
      sum_acc    <= sum_acc + (de_lvl ? rgb_q : '0);

      // h_cnt is the horizontal reference and keeps running across CHECK entry.
      if (hs_rise_c || state == ST_SEARCH) h_cnt <= '0;
      else                                 h_cnt <= sat_inc(h_cnt);

      if (de_rise_c) begin
        de_run   <= CNT_W'(1);
        run_open <= 1'b1;
      end else if (run_end_c) begin
        run_open <= 1'b0;
      end else if (de_lvl && run_open) begin
        de_run <= sat_inc(de_run);
      end

      if (in_check_c && run_end_c) active_lines <= sat_inc(active_lines);
      if (hs_rise_c)               line_cnt     <= sat_inc(line_cnt);

      // A coincident hsync edge belongs to the frame being opened.
      if (open_c || close_c) begin
        line_cnt     <= hs_rise_c ? CNT_W'(1) : '0;
        active_lines <= '0;
        sum_acc      <= de_lvl ? rgb_q : '0;
        run_open     <= 1'b0;
        frame_err    <= 1'b0;
      end

      if (close_c) begin
        frame_checksum <= sum_acc;
        frame_done     <= 1'b1;
        frame_count    <= frame_count + FCNT_W'(1);
        if (frame_bad_c) begin
          good_frames <= '0;
          locked      <= 1'b0;
        end else begin
          if (good_frames != '1) good_frames <= good_frames + GOOD_W'(1);
          if (good_frames >= LOCK_M1) locked <= 1'b1;
        end
      end else if (|det_c) begin
        good_frames <= '0;
        locked      <= 1'b0;
        frame_err   <= 1'b1;
      end
    end
  end

  assign err_h_total  = err_q[ERR_H_TOTAL];
  assign err_h_sync   = err_q[ERR_H_SYNC];
  assign err_h_active = err_q[ERR_H_ACTIVE];
  assign err_v_total  = err_q[ERR_V_TOTAL];
  assign err_v_active = err_q[ERR_V_ACTIVE];
  assign err_timeout  = err_q[ERR_TIMEOUT];

endmodule

// File: tb/tb_video_timing_checker.sv
// Scoreboard bench for video_timing_checker on a shrunken raster
// (32x10 clocks, 16x6 active) so whole frames stay short.
module tb_video_timing_checker;

  localparam int HA = 16, HT = 32, HS = 4, VA = 6, VT = 10, LF = 2;
  localparam int DE_START = 8, VS_LINE = 8;

  typedef struct packed {
    logic [23:0] csum;
    logic [15:0] cnt;
    logic        lock;
    logic [5:0]  errs;
  } exp_t;

  logic        clock_25 = 1'b0;
  logic        reset, h_sync, v_sync, data_enable, clear_errors;
  logic [23:0] rgb_channel;
  logic        locked, frame_done;
  logic [15:0] frame_count;
  logic [23:0] frame_checksum;
  logic        err_h_total, err_h_sync, err_h_active, err_v_total, err_v_active, err_timeout;
  logic [5:0]  errs_now;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clock_25 = ~clock_25;

  assign errs_now = {err_timeout, err_v_active, err_v_total, err_h_active, err_h_sync, err_h_total};

  video_timing_checker #(
    .H_ACTIVE(HA), .H_TOTAL(HT), .H_SYNC_W(HS), .V_ACTIVE(VA), .V_TOTAL(VT),
    .LOCK_FRAMES(LF), .SYNC_POL(1'b0)
  ) dut (
    .clock_25(clock_25), .reset(reset), .h_sync(h_sync), .v_sync(v_sync),
    .data_enable(data_enable), .rgb_channel(rgb_channel), .clear_errors(clear_errors),
    .locked(locked), .frame_done(frame_done), .frame_count(frame_count),
    .frame_checksum(frame_checksum), .err_h_total(err_h_total), .err_h_sync(err_h_sync),
    .err_h_active(err_h_active), .err_v_total(err_v_total), .err_v_active(err_v_active),
    .err_timeout(err_timeout)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [23:0] csum, input logic [15:0] cnt,
                          input logic lock, input logic [5:0] errs);
    exp_t e;
    e.csum = csum; e.cnt = cnt; e.lock = lock; e.errs = errs;
    exp_q.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_locked"},     32'(locked), 0);
    check({tag, "_frame_done"}, 32'(frame_done), 0);
    check({tag, "_count"},      32'(frame_count), 0);
    check({tag, "_checksum"},   32'(frame_checksum), 0);
    check({tag, "_errs"},       32'(errs_now), 0);
  endtask

  // Drives n_lines raster lines; vsync is asserted on lines VS_LINE..VT-1.
  task automatic run_frame(input logic [23:0] rgb, input int long_line, input int short_line,
                           input int de_lines, input int n_lines, input int clr_line);
    for (int l = 0; l < n_lines; l++) begin
      int len;
      int de_len;
      len    = (l == long_line) ? HT + 1 : HT;
      de_len = (l < de_lines) ? ((l == short_line) ? HA - 1 : HA) : 0;
      for (int p = 0; p < len; p++) begin
        @(negedge clock_25);
        h_sync       = (p < HS) ? 1'b0 : 1'b1;
        v_sync       = (l >= VS_LINE) ? 1'b0 : 1'b1;
        data_enable  = (p >= DE_START) && (p < DE_START + de_len);
        rgb_channel  = data_enable ? rgb : 24'h0;
        clear_errors = (l == clr_line) && (p == 10);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock_25);
      h_sync = 1'b1; v_sync = 1'b1; data_enable = 1'b0;
      rgb_channel = 24'h0; clear_errors = 1'b0;
    end
  endtask

  // Monitor: every frame_done must match the oldest expected frame result.
  always @(negedge clock_25) begin : monitor
    exp_t e;
    if (frame_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_frame_done: got count 0x%0h expected no frame at %0t",
                 frame_count, $time);
      end else begin
        e = exp_q.pop_front();
        check("frame_checksum", 32'(frame_checksum), 32'(e.csum));
        check("frame_count",    32'(frame_count),    32'(e.cnt));
        check("frame_locked",   32'(locked),         32'(e.lock));
        check("frame_errs",     32'(errs_now),       32'(e.errs));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; h_sync = 1'b1; v_sync = 1'b1; data_enable = 1'b0;
    rgb_channel = 24'h0; clear_errors = 1'b0;
    repeat (3) @(negedge clock_25);
    check_all_zero("reset");
    reset = 1'b0;
    idle(4);

    // Nominal raster, constant 1: first vsync only opens a frame.
    run_frame(24'h000001, -1, -1, VA, VT, -1);
    push_exp(24'h000060, 16'd1, 1'b0, 6'h00);
    run_frame(24'h000001, -1, -1, VA, VT, -1);
    push_exp(24'h000060, 16'd2, 1'b1, 6'h00);
    run_frame(24'h000001, -1, -1, VA, VT, -1);

    // Full-scale blue: 96 * 0xFF.
    push_exp(24'h005FA0, 16'd3, 1'b1, 6'h00);
    run_frame(24'h0000FF, -1, -1, VA, VT, -1);
    push_exp(24'h005FA0, 16'd4, 1'b1, 6'h00);
    run_frame(24'h0000FF, -1, -1, VA, VT, -1);
    check("locked_after_blue", 32'(locked), 1);

    // One 33-clock line, then two clean frames re-lock, then clear.
    push_exp(24'h000060, 16'd5, 1'b0, 6'h01);
    run_frame(24'h000001, 2, -1, VA, VT, -1);
    check("long_line_err", 32'(err_h_total), 1);
    check("long_line_unlock", 32'(locked), 0);
    push_exp(24'h000060, 16'd6, 1'b0, 6'h01);
    run_frame(24'h000001, -1, -1, VA, VT, -1);
    push_exp(24'h000060, 16'd7, 1'b1, 6'h01);
    run_frame(24'h000001, -1, -1, VA, VT, -1);
    check("relock", 32'(locked), 1);
    push_exp(24'h000060, 16'd8, 1'b1, 6'h00);
    run_frame(24'h000001, -1, -1, VA, VT, 0);
    check("cleared_errs", 32'(errs_now), 0);

    // Short DE run, then a frame with only 5 active lines.
    push_exp(24'h00005F, 16'd9, 1'b0, 6'h04);
    run_frame(24'h000001, -1, 1, VA, VT, -1);
    push_exp(24'h000050, 16'd10, 1'b0, 6'h14);
    run_frame(24'h000001, -1, -1, VA - 1, VT, -1);
    push_exp(24'h000060, 16'd11, 1'b0, 6'h00);
    run_frame(24'h000001, -1, -1, VA, VT, 0);

    // hsync stalled past 2*H_TOTAL clocks, then re-acquire.
    idle(2 * HT + 10);
    check("timeout_err", 32'(err_timeout), 1);
    check("timeout_unlock", 32'(locked), 0);
    run_frame(24'h000001, -1, -1, VA, VT, -1);
    push_exp(24'h000060, 16'd12, 1'b0, 6'h20);
    run_frame(24'h000001, -1, -1, VA, VT, -1);
    push_exp(24'h000060, 16'd13, 1'b1, 6'h20);
    run_frame(24'h000001, -1, -1, VA, VT, -1);

    // One-clock reset in the middle of a frame.
    run_frame(24'h000001, -1, -1, VA, 4, -1);
    @(negedge clock_25);
    reset = 1'b1;
    @(negedge clock_25);
    reset = 1'b0;
    check_all_zero("midreset");
    idle(3);
    run_frame(24'h000001, -1, -1, VA, VT, -1);
    push_exp(24'h000060, 16'd1, 1'b0, 6'h00);
    run_frame(24'h000001, -1, -1, VA, VT, -1);
    idle(5);
    check("pending_frames", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
